// File: rtl/x_multdiv.sv
// Iterative 32-bit signed multiply/divide unit for the execute stage.
// One operation takes a start cycle, 32 BUSY iterations and a one-cycle DONE.
module x_multdiv (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [31:0] ir_in,
    input  logic        flush,
    output logic        stall,
    output logic        md_ready,
    output logic [31:0] md_result,
    output logic        md_exception
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic [4:0]  count;
    logic        op_div;
    logic        neg_res;
    logic [31:0] opb;
    logic [63:0] acc;
    logic [33:0] rem;

    logic        is_mul;
    logic        is_div;
    logic        is_md;
    logic        start;
    logic        unused_ir;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [33:0] div_shifted;
    logic [33:0] rem_next;
    logic [31:0] q_next;
    logic [63:0] mul_signed;
    logic [31:0] div_signed;
    logic [31:0] final_res;
    logic        final_exc;

    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    assign is_mul    = (ir_in[31:27] == 5'b00000) && (ir_in[6:2] == 5'b00110);
    assign is_div    = (ir_in[31:27] == 5'b00000) && (ir_in[6:2] == 5'b00111);
    assign is_md     = is_mul | is_div;
    assign unused_ir = ^{ir_in[26:7], ir_in[1:0]};
    assign start     = (state == IDLE) & is_md & ~flush & reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = BUSY;
            BUSY: begin
                if (flush)
                    next_state = IDLE;
                else if (count == 5'd31)
                    next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        stall    = (start | (state == BUSY)) & ~flush & reset_n;
        md_ready = (state == DONE) & ~flush;
    end

    // Multiply: shift-add on magnitudes, multiplier sits in acc[31:0] and
    // shifts out as the partial product shifts in from the top.
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};

    // Divide: non-restoring on magnitudes; dividend bits leave acc[31:0] from
    // the top while quotient bits enter at the bottom.
    assign div_shifted = {rem[32:0], acc[31]};
    assign rem_next    = rem[33] ? (div_shifted + {2'b00, opb})
                                 : (div_shifted - {2'b00, opb});
    assign q_next      = {acc[30:0], ~rem_next[33]};

    always_comb begin
        mul_signed = neg_res ? (64'd0 - mul_next) : mul_next;
        div_signed = neg_res ? (32'd0 - q_next) : q_next;
        final_res  = '0;
        final_exc  = 1'b0;
        if (op_div) begin
            if (opb == 32'd0) begin
                final_res = '0;
                final_exc = 1'b1;
            end else begin
                final_res = div_signed;
                final_exc = ~neg_res & q_next[31];
            end
        end else begin
            final_res = mul_signed[31:0];
            final_exc = ~((&mul_signed[63:31]) | ~(|mul_signed[63:31]));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count        <= '0;
            op_div       <= 1'b0;
            neg_res      <= 1'b0;
            opb          <= '0;
            acc          <= '0;
            rem          <= '0;
            md_result    <= '0;
            md_exception <= 1'b0;
        end else if (start) begin
            count   <= '0;
            op_div  <= is_div;
            neg_res <= a_in[31] ^ b_in[31];
            opb     <= magnitude(b_in);
            acc     <= {32'd0, magnitude(a_in)};
            rem     <= '0;
        end else if ((state == BUSY) && !flush) begin
            count <= count + 5'd1;
            if (op_div) begin
                acc <= {acc[63:32], q_next};
                rem <= rem_next;
            end else begin
                acc <= mul_next;
            end
            if (count == 5'd31) begin
                md_result    <= final_res;
                md_exception <= final_exc;
            end
        end
    end

endmodule

// File: tb/tb_x_multdiv.sv
// Scoreboard bench for x_multdiv: a pipeline-like driver issues instructions,
// a negedge monitor pops expected results whenever md_ready pulses.
module tb_x_multdiv;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [31:0] ir_in = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        md_ready;
    logic [31:0] md_result;
    logic        md_exception;

    typedef struct packed {
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_res = '0;
    logic        last_exc = 1'b0;

    x_multdiv dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .a_in         (a_in),
        .b_in         (b_in),
        .ir_in        (ir_in),
        .flush        (flush),
        .stall        (stall),
        .md_ready     (md_ready),
        .md_result    (md_result),
        .md_exception (md_exception)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // kind: 0 = non-md instruction, 1 = mul, 2 = div
    function automatic logic [31:0] mk_ir(input int kind);
        logic [31:0] r;
        r = $urandom;
        case (kind)
            1: begin r[31:27] = 5'b00000; r[6:2] = 5'b00110; end
            2: begin r[31:27] = 5'b00000; r[6:2] = 5'b00111; end
            default: r[31] = 1'b1;
        endcase
        return r;
    endfunction

    function automatic exp_t ref_model(input int kind, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint p;
        int     sa;
        int     sbv;
        sa  = a;
        sbv = b;
        if (kind == 1) begin
            p     = longint'(sa) * longint'(sbv);
            e.res = p[31:0];
            e.exc = (longint'(int'(p)) != p);
        end else if (b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000;
            e.exc = 1'b1;
        end else begin
            e.res = sa / sbv;
            e.exc = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'd0;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = $urandom_range(0, 1000);
            4: v = 32'd0 - $urandom_range(1, 1000);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        if (md_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_ready: got md_ready=1 expected no pending op at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                check_output("md_result", md_result, mon_e.res);
                check_output("md_exception", {31'b0, md_exception}, {31'b0, mon_e.exc});
            end
        end
    end

    // Presents one instruction and holds it while stall is high, like the
    // decode/execute latch would; operands are scrambled during BUSY.
    task automatic apply_stimulus(input int kind, input logic [31:0] a, input logic [31:0] b,
                                  input bit use_exp, input logic [31:0] xr, input logic xe);
        int   cnt;
        bit   done;
        exp_t e;
        @(posedge clk); #1;
        ir_in = mk_ir(kind);
        a_in  = a;
        b_in  = b;
        if (kind != 0) begin
            e = use_exp ? '{res: xr, exc: xe} : ref_model(kind, a, b);
            sb.push_back(e);
            last_res = e.res;
            last_exc = e.exc;
        end
        cnt  = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (stall === 1'b1) begin
                cnt++;
                if (c > 0) begin
                    a_in = $urandom;
                    b_in = $urandom;
                end
            end else begin
                done = 1'b1;
                if (kind != 0) begin
                    check_output("stall_cycles", 32'(cnt), 32'd33);
                    check_output("ready_after_stall", {31'b0, md_ready}, 32'd1);
                end else begin
                    check_output("nonmd_stall_cycles", 32'(cnt), 32'd0);
                    check_output("nonmd_ready", {31'b0, md_ready}, 32'd0);
                end
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL stall_timeout: got stall stuck high expected release within 40 cycles");
        end
    endtask

    task automatic watch_idle(input string name, input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (stall !== 1'b0 || md_ready !== 1'b0) seen = 1'b1;
        end
        check_output(name, {31'b0, seen}, 32'd0);
        check_output({name, "_result"}, md_result, last_res);
        check_output({name, "_exception"}, {31'b0, md_exception}, {31'b0, last_exc});
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit all_high;
        int kind;

        ir_in = mk_ir(1);
        #3;
        check_output("reset_stall", {31'b0, stall}, 32'd0);
        check_output("reset_ready", {31'b0, md_ready}, 32'd0);
        check_output("reset_result", md_result, 32'd0);
        check_output("reset_exception", {31'b0, md_exception}, 32'd0);
        ir_in = mk_ir(0);
        #19 reset_n = 1'b1;

        apply_stimulus(1, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 1'b0);
        apply_stimulus(2, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0);
        apply_stimulus(2, 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 1'b0);
        apply_stimulus(2, 32'd5, 32'd0, 1'b1, 32'd0, 1'b1);
        apply_stimulus(1, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'd0, 1'b1);
        apply_stimulus(2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1);
        apply_stimulus(0, 32'd1, 32'd2, 1'b0, 32'd0, 1'b0);

        // Flush coinciding with the start cycle must not capture anything.
        @(posedge clk); #1;
        ir_in = mk_ir(1);
        a_in  = 32'd3;
        b_in  = 32'd4;
        flush = 1'b1;
        @(negedge clk);
        check_output("flush_start_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        ir_in = mk_ir(0);
        watch_idle("flush_start_idle", 40);

        // Flush in the 10th BUSY cycle abandons the multiply.
        @(posedge clk); #1;
        ir_in = mk_ir(1);
        a_in  = 32'd1234;
        b_in  = 32'd5678;
        @(posedge clk); #1;
        ir_in    = mk_ir(0);
        all_high = 1'b1;
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            if (stall !== 1'b1) all_high = 1'b0;
            @(posedge clk); #1;
        end
        check_output("busy_stall_high", {31'b0, all_high}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        check_output("flush_busy_stall", {31'b0, stall}, 32'd0);
        check_output("flush_busy_ready", {31'b0, md_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        watch_idle("flush_busy_idle", 40);

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 4);
            kind = (kind == 0) ? 0 : ((kind <= 2) ? 1 : 2);
            apply_stimulus(kind, pick_operand(), pick_operand(), 1'b0, 32'd0, 1'b0);
        end

        // Reset in BUSY cycle 20 clears results and abandons the operation.
        apply_stimulus(1, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 1'b0);
        @(posedge clk); #1;
        ir_in = mk_ir(2);
        a_in  = 32'd999;
        b_in  = 32'd3;
        repeat (20) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_output("midreset_stall", {31'b0, stall}, 32'd0);
        check_output("midreset_result", md_result, 32'd0);
        check_output("midreset_exception", {31'b0, md_exception}, 32'd0);
        last_res = '0;
        last_exc = 1'b0;
        ir_in = mk_ir(1);
        #1;
        check_output("reset_md_stall", {31'b0, stall}, 32'd0);
        ir_in = mk_ir(0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        watch_idle("post_reset_idle", 40);

        apply_stimulus(2, 32'hFFFF_FF9C, 32'd7, 1'b0, 32'd0, 1'b0);
        apply_stimulus(1, $urandom, $urandom, 1'b0, 32'd0, 1'b0);
        apply_stimulus(0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);

        check_output("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/x_multdiv.md
X_MULTDIV -- requirements
Module: x_multdiv

Interface
REQ-001 Parameters: none; the datapath is fixed at 32 bits.
REQ-002 clk  input  1  rising-edge system clock shared with the pipeline latches.
REQ-003 reset_n  input  1  asynchronous reset, active-low.
REQ-004 a_in  input  32  operand A from the decode/execute latch a_out.
REQ-005 b_in  input  32  operand B from the decode/execute latch b_out.
REQ-006 ir_in  input  32  instruction from the decode/execute latch ir_out.
REQ-007 flush  input  1  branch squash; kills any pending or starting operation.
REQ-008 stall  output  1  high = hold the decode/execute latch (drives its enable low).
REQ-009 md_ready  output  1  one-cycle pulse; md_result and md_exception are valid.
REQ-010 md_result  output  32  signed product or quotient, registered.
REQ-011 md_exception  output  1  overflow or divide-by-zero flag, registered.

Function
REQ-012 Decode is combinational from ir_in: is_mul = (ir_in[31:27]==5'b00000) && (ir_in[6:2]==5'b00110).
REQ-013 Divide decode is is_div = (ir_in[31:27]==5'b00000) && (ir_in[6:2]==5'b00111); is_md = is_mul | is_div.
REQ-014 FSM states are IDLE, BUSY and DONE; the iteration counter is 5 bits.
REQ-015 start = IDLE & is_md & !flush; on start, capture a_in, b_in and the op type, clear the counter, and go to BUSY.
REQ-016 BUSY performs one iteration per cycle: shift-add for multiply, non-restoring on magnitudes for divide.
REQ-017 BUSY increments the counter each cycle; at count==31 (the 32nd BUSY cycle) it goes to DONE.
REQ-018 DONE lasts exactly one cycle and then goes to IDLE unconditionally.
REQ-019 stall = (start | BUSY) & !flush; it is combinational and low in IDLE without start and in DONE.
REQ-020 Latency: stall is high for 33 consecutive cycles (the start cycle plus 32 BUSY cycles); md_ready is in the 34th cycle.
REQ-021 md_ready = DONE & !flush.
REQ-022 md_result and md_exception are loaded on the BUSY-to-DONE edge and hold until the next load or reset.
REQ-023 Multiply uses 32x32 signed operands; md_result = low 32 bits of the 64-bit product.
REQ-024 Multiply sets md_exception=1 when the product is not representable in 32-bit signed (upper 33 bits not all equal).
REQ-025 Divide is signed and truncates toward zero; the remainder is discarded.
REQ-026 Divide by zero (b captured == 0) gives md_result=0 and md_exception=1, with normal latency.
REQ-027 Divide of 0x80000000 by 0xFFFFFFFF gives md_result=0x80000000 and md_exception=1.
REQ-028 flush in BUSY: next state IDLE, no md_ready, and md_result/md_exception are unchanged.
REQ-029 flush in the start cycle: no capture and the state stays IDLE.
REQ-030 Non-md instructions never assert stall or md_ready.
REQ-031 A back-to-back md instruction loaded during DONE starts on the following IDLE cycle.
REQ-032 Operand inputs are ignored outside the start cycle; changes during BUSY have no effect.

Reset
REQ-033 reset_n low immediately forces: state IDLE, counter 0, operand and accumulator registers 0, md_result 0, md_exception 0.
REQ-034 With reset_n low, stall=0 and md_ready=0 regardless of ir_in.
REQ-035 Reset asserted mid-BUSY abandons the operation; no md_ready follows reset release.
REQ-036 After reset_n rises, the first rising clk edge may start an operation.

Verification
REQ-037 mul, a=7, b=0xFFFFFFFD -> stall high 33 cycles, then md_ready=1, md_result=0xFFFFFFEB, md_exception=0.
REQ-038 div, a=100, b=7 -> md_result=14; div, a=0xFFFFFF9C (-100), b=7 -> md_result=0xFFFFFFF2 (-14); md_exception=0 for both.
REQ-039 div, a=5, b=0 -> md_ready in cycle 34, md_result=0, md_exception=1.
REQ-040 mul, a=0x00010000, b=0x00010000 -> md_result=0x00000000, md_exception=1.
REQ-041 mul started, flush=1 in the 10th BUSY cycle -> stall low that cycle, FSM IDLE next cycle, md_ready never pulses, md_result unchanged.
REQ-042 reset_n low in BUSY cycle 20 -> stall=0, md_result=0 immediately; after release with ir_in=add, stall stays 0.
